// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared op encodings, FSM states and sizing for mult_div_unit
package mult_div_unit_pkg;
  localparam int DEF_DATA_BITS = 32;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  function automatic int cnt_width(int n);
    return $clog2(n) + 1;
  endfunction
  localparam int DEF_CNT_BITS = cnt_width(DEF_DATA_BITS);
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on a shared adder
module muldiv_step #(
  parameter int N = 32
) (
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   opnd,
  input  logic           div,
  output logic [2*N-1:0] acc_next,
  output logic           q_bit
);
  logic [N:0] x, y;
  logic [N+1:0] sum;
  always_comb begin
    x = div ? acc[2*N-1:N-1] : {1'b0, acc[2*N-1:N]};
    y = div ? ~{1'b0, opnd} : (acc[0] ? {1'b0, opnd} : '0);
    sum = {1'b0, x} + {1'b0, y} + {{(N+1){1'b0}}, div};
    q_bit = div & sum[N+1];
    acc_next = div ? {(q_bit ? sum[N-1:0] : x[N-1:0]), acc[N-2:0], 1'b0}
                   : {sum[N:0], acc[N-1:1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU owning HI/LO; MULDIV_EARLY_OUT_EN enables multiply early-out
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [DATA_BITS-1:0] hi,
  output logic [DATA_BITS-1:0] lo
);
  localparam int N = DATA_BITS;
  localparam int CW = cnt_width(N);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] acc, acc_next, prod;
  logic [N-1:0] opnd, a_raw, mag_a, mag_b, quo, rem, fix_hi, fix_lo;
  logic is_div, neg_q, neg_r, dz, q_bit, sa, sb;
  muldiv_step #(.N(N)) u_step (
    .acc(acc), .opnd(opnd), .div(is_div), .acc_next(acc_next), .q_bit(q_bit)
  );
  always_comb begin
    sa = op[0] & a[N-1];
    sb = op[0] & b[N-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[N-1:0] : acc[N-1:0];
    rem = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
    fix_hi = !is_div ? prod[2*N-1:N] : dz ? a_raw : rem;
    fix_lo = !is_div ? prod[N-1:0] : dz ? '1 : quo;
  end
`ifdef MULDIV_EARLY_OUT_EN
  logic [N-1:0] mask;
  always_comb mask = N'(({{N{1'b0}}, 1'b1} << cnt) - 1'b1);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      a_raw <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz <= op[1] & (b == '0);
            a_raw <= a;
            opnd <= op[1] ? mag_b : mag_a;
            acc <= {{N{1'b0}}, op[1] ? mag_a : mag_b};
            cnt <= CW'(N);
            busy <= 1'b1;
            div_by_zero <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
          if (!is_div && (acc[N-1:0] & mask) == '0) begin
            acc <= acc >> cnt;
            state <= FIX;
          end else begin
`else
          begin
`endif
            acc <= acc_next | (2*N)'(q_bit);
            cnt <= cnt - 1'b1;
            state <= cnt == CW'(1) ? FIX : RUN;
          end
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
          div_by_zero <= dz;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;
  localparam int N = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, hi_we, lo_we, busy, done, div_by_zero;
  logic [1:0] op;
  logic [N-1:0] a, b, wdata, hi, lo;
  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic dz;
    int t0;
    bit early;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  mult_div_unit #(.DATA_BITS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 want done=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        lat = cyc - e.t0;
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("busy_in_done", busy, 0);
        if (e.early) chk("latency_early_lt34", lat < 34, 1);
        else chk("latency", lat, 34);
      end
    end
  end
  task automatic issue_now(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic [N-1:0] eh, input logic [N-1:0] el, input logic ed);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    sb.push_back('{eh, el, ed, cyc, EARLY && !o[1]});
    @(negedge clk);
    start = 1'b0;
    op = ~op;
    a = ~a;
    b = ~b;
  endtask
  task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] eh, input logic [N-1:0] el, input logic ed);
    @(negedge clk);
    issue_now(o, x, y, eh, el, ed);
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done want done within 60 cycles");
      sb.delete();
    end
  endtask
  task automatic wait_done();
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0); drain();
    issue(2'b01, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0); drain();
    issue(2'b01, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'd15, 1'b0); drain();
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0); drain();
    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0); drain();
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0); drain();
    issue(2'b10, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1); drain();
    repeat (3) @(negedge clk);
    chk("dz_held", div_by_zero, 1);
    issue(2'b00, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
    chk("dz_cleared", div_by_zero, 0);
    drain();
    issue(2'b11, 32'h80000005, 32'h0, 32'h80000005, 32'hFFFFFFFF, 1'b1); drain();
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h5A5A5A5A;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi", hi, 32'hA5A5A5A5);
    chk("mtlo", lo, 32'h5A5A5A5A);
    hi_we = 1'b1;
    wdata = 32'h11111111;
    issue_now(2'b00, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
    hi_we = 1'b0;
    chk("mthi_with_start", hi, 32'h11111111);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    a = 32'd100;
    b = 32'd7;
    hi_we = 1'b1;
    wdata = 32'hBADBAD00;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    chk("busy_second_start", busy, 1);
    chk("hi_we_while_busy", hi, 32'h11111111);
    wait_done();
    issue_now(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    drain();
    issue(2'b00, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    sb.delete();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'b00, 32'h1234, 32'd1, 32'h0, 32'h1234, 1'b0); drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
